// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift-source unit: shift operations and FSM states.
// The reserved-op helper lets the unit collapse unsupported ops into a pass-through.
package shift_pkg;

   typedef enum logic [2:0] {
      OP_SLL = 3'b000,
      OP_SRL = 3'b001,
      OP_SRA = 3'b010,
      OP_ROR = 3'b011,
      OP_ROL = 3'b100
   } shift_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } shift_state_e;

   // Encodings above OP_ROL carry no shift; the unit treats them as a zero-length pass-through.
   function automatic logic op_is_reserved(input logic [2:0] op);
      return op > 3'(OP_ROL);
   endfunction

endpackage

// File: rtl/shift_src_mux.sv
// Parametrised NSRC:1 operand select; any index without a matching source falls back to source 0.
module shift_src_mux #(
   parameter int WIDTH = 32,
   parameter int NSRC  = 4,
   parameter int SELW  = $clog2(NSRC)
) (
   input  logic [SELW-1:0]       sel,
   input  logic [NSRC*WIDTH-1:0] src_data,
   output logic [WIDTH-1:0]      data_out
);

   // Source 0 is the default, so out-of-range indices need no separate branch.
   always_comb begin
      data_out = src_data[WIDTH-1:0];
      for (int i = 1; i < NSRC; i++) begin
         if (sel == SELW'(i)) begin
            data_out = src_data[i*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/shift_src_unit.sv
// Iterative shifter fed by a parametrised operand select: one bit of shift per clock,
// with a start/busy/done handshake toward the control FSM.
module shift_src_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NSRC  = 4,
   parameter int SELW  = $clog2(NSRC),
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [SELW-1:0]       data_sel,
   input  logic [NSRC*WIDTH-1:0] src_data,
   input  logic                  amt_sel,
   input  logic [SHW-1:0]        amt_imm,
   input  logic [WIDTH-1:0]      amt_reg,
   output logic                  busy,
   output logic                  done,
   output logic [WIDTH-1:0]      result
);

   shift_state_e     state, state_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [SHW-1:0]   count, count_nxt;
   logic [2:0]       op_q, op_nxt;
   logic [WIDTH-1:0] result_nxt;
   logic [WIDTH-1:0] sel_data;
   logic [SHW-1:0]   amt;
   logic [WIDTH-1:0] acc_shifted;

   // Only the low SHW bits of the register amount matter (shift modulo WIDTH).
   logic unused_amt_hi;
   assign unused_amt_hi = ^amt_reg[WIDTH-1:SHW];

   shift_src_mux #(
      .WIDTH (WIDTH),
      .NSRC  (NSRC),
      .SELW  (SELW)
   ) u_src_mux (
      .sel      (data_sel),
      .src_data (src_data),
      .data_out (sel_data)
   );

   assign amt = amt_sel ? amt_reg[SHW-1:0] : amt_imm;

   // Single-bit step of the latched operation.
   always_comb begin
      acc_shifted = acc;
      case (op_q)
         OP_SLL:  acc_shifted = {acc[WIDTH-2:0], 1'b0};
         OP_SRL:  acc_shifted = {1'b0, acc[WIDTH-1:1]};
         OP_SRA:  acc_shifted = {acc[WIDTH-1], acc[WIDTH-1:1]};
         OP_ROR:  acc_shifted = {acc[0], acc[WIDTH-1:1]};
         OP_ROL:  acc_shifted = {acc[WIDTH-2:0], acc[WIDTH-1]};
         default: acc_shifted = acc;
      endcase
   end

   // Next-state and datapath update; result is only loaded on the transition into DONE.
   always_comb begin
      state_nxt  = state;
      acc_nxt    = acc;
      count_nxt  = count;
      op_nxt     = op_q;
      result_nxt = result;
      case (state)
         ST_IDLE: begin
            if (start) begin
               acc_nxt   = sel_data;
               count_nxt = op_is_reserved(op) ? '0 : amt;
               op_nxt    = op;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (count == '0) begin
               result_nxt = acc;
               state_nxt  = ST_DONE;
            end else begin
               acc_nxt   = acc_shifted;
               count_nxt = count - SHW'(1);
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         acc    <= '0;
         count  <= '0;
         op_q   <= '0;
         result <= '0;
      end else begin
         state  <= state_nxt;
         acc    <= acc_nxt;
         count  <= count_nxt;
         op_q   <= op_nxt;
         result <= result_nxt;
      end
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_src_unit.sv
// Randomised and directed checks of shift_src_unit against an arithmetic reference model.
module tb_shift_src_unit;

   localparam int WIDTH = 32;
   localparam int NSRC  = 4;
   localparam int SELW  = 2;
   localparam int SHW   = 5;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  start;
   logic [2:0]            op;
   logic [SELW-1:0]       dataSel;
   logic [NSRC*WIDTH-1:0] srcData;
   logic                  amtSel;
   logic [SHW-1:0]        amtImm;
   logic [WIDTH-1:0]      amtReg;
   logic                  busy;
   logic                  done;
   logic [WIDTH-1:0]      result;

   int vecCount = 0;
   int errCount = 0;
   logic [WIDTH-1:0] lastResult = '0;

   shift_src_unit #(
      .WIDTH (WIDTH),
      .NSRC  (NSRC)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .data_sel (dataSel),
      .src_data (srcData),
      .amt_sel  (amtSel),
      .amt_imm  (amtImm),
      .amt_reg  (amtReg),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Whole-word shift/rotate, straight from the operation definitions.
   function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] x, input int n);
      case (o)
         3'd0:    return x << n;
         3'd1:    return x >> n;
         3'd2:    return 32'($signed(x) >>> n);
         3'd3:    return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
         3'd4:    return (n == 0) ? x : ((x << n) | (x >> (32 - n)));
         default: return x;
      endcase
   endfunction

   function automatic int effAmount(input logic [2:0] o, input logic aSel, input logic [4:0] imm, input logic [31:0] regv);
      if (o > 3'd4) return 0;
      return aSel ? int'(regv % 32) : int'(imm);
   endfunction

   task automatic scrambleInputs();
      srcData = {$urandom, $urandom, $urandom, $urandom};
      op      = 3'($urandom);
      dataSel = SELW'($urandom);
      amtSel  = 1'($urandom);
      amtImm  = SHW'($urandom);
      amtReg  = $urandom;
   endtask

   task automatic applyStimulus(input string tag, input logic [2:0] opv, input logic [1:0] sel,
                                input logic [31:0] srcv, input logic aSel, input logic [4:0] imm,
                                input logic [31:0] regv, input logic inject, input logic [31:0] expected);
      int effAmt;
      int edges;
      int busyCycles;
      effAmt = effAmount(opv, aSel, imm, regv);
      srcData = {$urandom, $urandom, $urandom, $urandom};
      srcData[sel*WIDTH +: WIDTH] = srcv;
      op      = opv;
      dataSel = sel;
      amtSel  = aSel;
      amtImm  = imm;
      amtReg  = regv;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      scrambleInputs();
      checkOutput({tag, "/busy_after_start"}, 32'(busy), 32'd1);
      checkOutput({tag, "/result_held"}, result, lastResult);
      edges = 0;
      busyCycles = 0;
      while (!done && edges < 40) begin
         if (busy) busyCycles++;
         if (inject && edges == 1) begin
            start   = 1'b1;
            op      = opv ^ 3'b001;
            dataSel = sel + 2'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         edges++;
         if (!done) scrambleInputs();
      end
      start = 1'b0;
      checkOutput({tag, "/latency"}, 32'(edges), 32'(effAmt + 1));
      checkOutput({tag, "/busy_cycles"}, 32'(busyCycles), 32'(effAmt + 1));
      checkOutput({tag, "/result"}, result, expected);
      @(posedge clk); #1;
      checkOutput({tag, "/done_pulse"}, 32'(done), 32'd0);
      checkOutput({tag, "/idle"}, 32'(busy), 32'd0);
      checkOutput({tag, "/result_stable"}, result, expected);
      lastResult = expected;
   endtask

   initial begin
      logic [2:0]  ro;
      logic [1:0]  rs;
      logic [31:0] rv;
      logic        ra;
      logic [4:0]  ri;
      logic [31:0] rr;
      reset = 1'b1;
      start = 1'b0;
      scrambleInputs();
      #12;
      checkOutput("reset/busy", 32'(busy), 32'd0);
      checkOutput("reset/done", 32'(done), 32'd0);
      checkOutput("reset/result", result, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      applyStimulus("sll4", 3'd0, 2'd0, 32'h0000_0001, 1'b0, 5'd4, 32'h0, 1'b0, 32'h0000_0010);
      applyStimulus("sra31", 3'd2, 2'd2, 32'h8000_0000, 1'b0, 5'd31, 32'h0, 1'b0, 32'hFFFF_FFFF);
      applyStimulus("srl31", 3'd1, 2'd2, 32'h8000_0000, 1'b0, 5'd31, 32'h0, 1'b0, 32'h0000_0001);
      applyStimulus("ror_reg", 3'd3, 2'd1, 32'h1234_5678, 1'b1, 5'd0, 32'hFFFF_FF08, 1'b0, 32'h7812_3456);
      applyStimulus("rol8", 3'd4, 2'd1, 32'h1234_5678, 1'b0, 5'd8, 32'h0, 1'b0, 32'h3456_7812);
      applyStimulus("sll0", 3'd0, 2'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 32'hDEAD_BEEF);
      applyStimulus("rsv110", 3'd6, 2'd3, 32'hDEAD_BEEF, 1'b0, 5'd17, 32'h0, 1'b0, 32'hDEAD_BEEF);
      applyStimulus("start_busy", 3'd0, 2'd0, 32'h0000_0003, 1'b0, 5'd6, 32'h0, 1'b1, 32'h0000_00C0);

      // Abort a 20-bit shift in its third cycle.
      srcData = {$urandom, $urandom, $urandom, $urandom};
      srcData[WIDTH-1:0] = 32'h0000_0001;
      op = 3'd0; dataSel = 2'd0; amtSel = 1'b0; amtImm = 5'd20;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      checkOutput("abort/busy", 32'(busy), 32'd0);
      checkOutput("abort/done", 32'(done), 32'd0);
      checkOutput("abort/result", result, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      lastResult = '0;
      applyStimulus("post_reset", 3'd0, 2'd0, 32'h0000_0001, 1'b0, 5'd1, 32'h0, 1'b0, 32'h0000_0002);

      for (int k = 0; k < 24; k++) begin
         ro = 3'($urandom_range(0, 7));
         rs = 2'($urandom);
         rv = $urandom;
         ra = 1'($urandom);
         ri = 5'($urandom);
         rr = $urandom;
         applyStimulus($sformatf("rand%0d", k), ro, rs, rv, ra, ri, rr,
                       (effAmount(ro, ra, ri, rr) >= 3) ? 1'($urandom) : 1'b0,
                       refModel(ro, rv, effAmount(ro, ra, ri, rr)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
